spi_ram_master: RTL and testbench

Same-clock SPI master that drives the serial side of the SPI-slave/single-port-RAM wrapper: MOSI, SS_n, and samples MISO. A host issues one 10-bit RAM frame per request: a 2-bit command plus 8-bit payload. The block serialises the frame MSB-first and, for read-data frames, collects the 8-bit RAM reply from MISO. It sits directly upstream of the wrapper and serves as both the system-level driver and the bench stimulus source.

---
 rtl/spi_ram_master.sv | 144 ++++++++++++++
 tb/tb_spi_ram_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// SPI master for the SPI-slave/RAM wrapper: shifts a 10-bit {cmd,data} frame out MSB-first
// and, for read-data frames, collects the 8-bit reply from MISO. All outputs are registered.
module spi_ram_master #(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SHIFT, S_TURN, S_RECV, S_END, S_GAP
  } state_t;

  localparam logic [3:0] RDW_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t     state_q, state_d;
  logic [9:0] frame_q, frame_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       mosi_q, mosi_d;
  logic       ss_n_q, ss_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rdv_q, rdv_d;
  logic       is_read;

  assign is_read = (frame_q[9:8] == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      rd_data_q <= '0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdv_q     <= rdv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    rdv_d     = 1'b0;
    mosi_d    = 1'b0;

    case (state_q)
      S_IDLE:   ;
      S_SELECT: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd9) begin
          cnt_d   = '0;
          state_d = is_read ? S_TURN : S_END;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_TURN: begin
        if (cnt_q == RDW_LAST) begin
          cnt_d   = '0;
          state_d = S_RECV;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_RECV: begin
        if (cnt_q == 4'd7) begin
          cnt_d   = '0;
          state_d = S_END;
        end else cnt_d = cnt_q + 4'd1;
      end
      S_END: begin
        cnt_d   = '0;
        state_d = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // A start is taken on any edge that would otherwise land in IDLE, so the
    // last GAP cycle (or END when GAP=0) can launch the next frame back-to-back.
    if (state_d == S_IDLE && start) begin
      state_d = S_SELECT;
      frame_d = {cmd, data};
    end

    // Outputs are derived from the next state so they register alongside it.
    ss_n_d = !(state_d inside {S_SELECT, S_SHIFT, S_TURN, S_RECV});
    busy_d = (state_d != S_IDLE);
    if (state_d == S_SELECT) mosi_d = frame_d[9];
    if (state_d == S_SHIFT)  mosi_d = frame_q[4'd9 - cnt_d];
    if (state_d == S_RECV)   shreg_d = {shreg_q[6:0], MISO};
    if (state_d == S_END) begin
      done_d = 1'b1;
      if (is_read) begin
        rd_data_d = shreg_q;
        rdv_d     = 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rdv_q;
  assign MOSI     = mosi_q;
  assign SS_n     = ss_n_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Scoreboard bench for spi_ram_master: driver pushes expected frames, negedge monitors
// pop and check MOSI stream, SS_n low time, latency and read data.
`timescale 1ns/1ps
module tb_spi_ram_master;
  localparam int RDW = 2;

  logic clk = 1'b0;
  logic rst;
  logic start, MISO, busy, done, rd_valid, MOSI, SS_n;
  logic [1:0] cmd;
  logic [7:0] data, rd_data;
  logic start1, MISO1, busy1, done1, rd_valid1, MOSI1, SS_n1;
  logic [1:0] cmd1;
  logic [7:0] data1, rd_data1;

  spi_ram_master #(.RD_WAIT(RDW), .GAP(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .data(data),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO));

  spi_ram_master #(.RD_WAIT(1), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cmd(cmd1), .data(data1),
    .busy(busy1), .done(done1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .MOSI(MOSI1), .SS_n(SS_n1), .MISO(MISO1));

  typedef struct {
    logic [9:0] f;
    logic       rd;
    logic [7:0] exp_rd;
    int         lat;
    int         t0;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] mem [0:255];
  logic [7:0] wa, ra, last_rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic frame_chk(input string n, input exp_t e, input int lc, input logic mb [0:63],
                           input logic rdv, input logic [7:0] rdd);
    int errs = 0;
    logic b;
    for (int i = 0; i < lc; i++) begin
      b = (i == 0) ? e.f[9] : ((i <= 10) ? e.f[10-i] : 1'b0);
      if (mb[i] !== b) errs++;
    end
    check({n, "_mosi_errs"}, errs, 0);
    check({n, "_ss_low"}, lc, e.lat);
    check({n, "_latency"}, cyc - e.t0, e.lat);
    check({n, "_rd_valid"}, {31'd0, rdv}, {31'd0, e.rd});
    check({n, "_rd_data"}, {24'd0, rdd}, {24'd0, e.exp_rd});
  endtask

  // Monitor, default DUT
  int lc0 = 0;
  logic mb0 [0:63];
  always @(negedge clk) begin
    if (rst) lc0 = 0;
    else begin
      if (!SS_n && lc0 < 64) begin mb0[lc0] = MOSI; lc0++; end
      if (done) begin
        check("d0_done_expected", {31'd0, q0.size() > 0}, 1);
        if (q0.size() > 0) begin
          e0 = q0.pop_front();
          frame_chk("d0", e0, lc0, mb0, rd_valid, rd_data);
        end
        lc0 = 0;
      end else if (rd_valid) check("d0_rdv_without_done", {31'd0, rd_valid}, 0);
    end
  end

  // Monitor, RD_WAIT=1 / GAP=0 DUT, including SS_n high time between frames
  int lc1 = 0, hi1 = 0;
  bit seen_low1 = 0;
  logic mb1 [0:63];
  always @(negedge clk) begin
    if (rst) begin lc1 = 0; hi1 = 0; seen_low1 = 0; end
    else begin
      if (!SS_n1) begin
        if (hi1 > 0) check("d1_ss_high_between", hi1, 1);
        hi1 = 0;
        seen_low1 = 1;
        if (lc1 < 64) begin mb1[lc1] = MOSI1; lc1++; end
      end else if (seen_low1) hi1++;
      if (done1) begin
        check("d1_done_expected", {31'd0, q1.size() > 0}, 1);
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          frame_chk("d1", e1, lc1, mb1, rd_valid1, rd_data1);
        end
        lc1 = 0;
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [7:0] d, input bit poke);
    exp_t e;
    int k;
    logic [7:0] rb;
    rb = 8'h00;
    case (c)
      2'b00: wa = d;
      2'b01: mem[wa] = d;
      2'b10: ra = d;
      default: begin rb = mem[ra]; last_rd = rb; end
    endcase
    @(posedge clk); #1 start = 1'b1; cmd = c; data = d;
    @(posedge clk); #1 start = 1'b0;
    e.f = {c, d}; e.rd = (c == 2'b11); e.exp_rd = last_rd;
    e.lat = (c == 2'b11) ? 19 + RDW : 11; e.t0 = cyc;
    q0.push_back(e);
    k = 0;
    while (busy && k < 80) begin
      cmd = 2'($urandom); data = 8'($urandom);
      start = poke && (k == 3);
      if (poke && k == 3) cmd = 2'b01;
      if (c == 2'b11 && k >= 10 + RDW && k <= 17 + RDW) MISO = rb[17 + RDW - k];
      @(posedge clk); #1 k++;
    end
    start = 1'b0; MISO = 1'b0;
    check("d0_busy_bounded", {31'd0, k >= 80}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k;
    bit second;
    logic [7:0] b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    wa = 0; ra = 0; last_rd = 0;
    rst = 1'b1; start = 0; cmd = 0; data = 0; MISO = 0;
    start1 = 0; cmd1 = 0; data1 = 0; MISO1 = 0;
    #12;
    check("reset_ss_n", {31'd0, SS_n}, 1);
    check("reset_mosi", {31'd0, MOSI}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_rd_valid", {31'd0, rd_valid}, 0);
    check("reset_rd_data", {24'd0, rd_data}, 0);
    @(posedge clk); #2 rst = 1'b0;

    send(2'b00, 8'hA5, 1'b1);              // write-address with a stray start mid-shift
    send(2'b00, 8'h10, 1'b0);              // round trip
    send(2'b01, 8'h5A, 1'b0);
    send(2'b10, 8'h10, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    send(2'b00, 8'h77, 1'b0);              // rd_data must hold 5A

    // Reset mid-SHIFT
    @(posedge clk); #1 start = 1'b1; cmd = 2'b00; data = 8'h3C;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1; #1;
    check("midrst_ss_n", {31'd0, SS_n}, 1);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_rd_data", {24'd0, rd_data}, 0);
    check("midrst_done", {31'd0, done}, 0);
    last_rd = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    send(2'b00, 8'h3C, 1'b0);

    // RD_WAIT=1, GAP=0: scripted C3 reply, then a back-to-back write-address
    b1 = 8'hC3;
    @(posedge clk); #1 start1 = 1'b1; cmd1 = 2'b11; data1 = 8'h00;
    @(posedge clk); #1 start1 = 1'b0;
    q1.push_back('{f: 10'h300, rd: 1'b1, exp_rd: 8'hC3, lat: 20, t0: cyc});
    k = 0; second = 0;
    while (k < 100 && !(second && !busy1)) begin
      start1 = 1'b0;
      data1 = 8'($urandom);
      if (k >= 11 && k <= 18) MISO1 = b1[18 - k];
      if (done1 && !second) begin start1 = 1'b1; cmd1 = 2'b00; data1 = 8'h81; end
      @(posedge clk); #1 k++;
      if (start1) begin
        start1 = 1'b0; second = 1;
        q1.push_back('{f: 10'h081, rd: 1'b0, exp_rd: 8'hC3, lat: 11, t0: cyc});
      end
    end
    check("d1_bounded", {31'd0, k >= 100}, 0);

    repeat (5) @(posedge clk);
    #1;
    check("d0_queue_drained", q0.size(), 0);
    check("d1_queue_drained", q1.size(), 0);
    check("d0_idle_end", {31'd0, busy}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
